seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display. It is the successor to the fixed 8-digit BCD scanner and sits between the game/score logic and the board's segment/anode pins. It adds:
- configurable digit count and refresh rate
- hex or BCD decoding
- per-digit decimal point and blank masks
- leading-zero suppression
- frame-coherent input snapshots
- an anti-ghosting dead cycle
- optional blinking

## Interface
Parameters:
- NUM_DIGITS, 8, digits scanned; legal 2..16.
- TICK_DIV, 100000, clock cycles per digit slot; legal >= 3.
- BLINK_FRAMES, 64, frames per blink half-period; legal >= 1.

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- digits  in  4*NUM_DIGITS  digit i = digits[4i+3:4i]; digit 0 is the rightmost.
- dp  in  NUM_DIGITS  decimal point enable per digit; active-high.
- blank  in  NUM_DIGITS  force digit dark (segments and dp); active-high.
- blink  in  NUM_DIGITS  blink mask; active-high. Used only with SEG_BLINK_EN.
- hex_mode  in  1  selects decoding of values 10..15: 1 = A b C d E F, 0 = dark.
- lz_blank  in  1  leading-zero suppression enable.
- segment  out  8  {a,b,c,d,e,f,g,dp}, bit7 = a; active-low; registered.
- enable  out  NUM_DIGITS  anode select, bit i = digit i; active-low; registered.
- frame_tick  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Prescaler counts 0..TICK_DIV-1. The cycle where it equals TICK_DIV-1 is a "tick".
- Slot pointer ptr is $clog2(NUM_DIGITS) bits wide and resets to NUM_DIGITS-1.
  - On a tick: ptr = (ptr == NUM_DIGITS-1) ? 0 : ptr+1.
  - On a wrap to 0: digits, dp, blank, blink, hex_mode and lz_blank are latched into the snapshot, and frame_tick = 1 on the following cycle.
- All decoding uses the snapshot only. Input changes mid-frame are invisible until the next frame.
- Decode, active-low with dp bit = 1:
  - 0 = 00000011, 1 = 10011111, 2 = 00100101, 3 = 00001101, 4 = 10011001
  - 5 = 01001001, 6 = 01000001, 7 = 00011111, 8 = 00000001, 9 = 00001001
  - A = 00010001, b = 11000001, C = 01100011, d = 10000101, E = 01100001, F = 01110001
- Values 10..15 with hex_mode = 0 produce 11111111.
- dp[i] = 1 clears bit0.
- Leading-zero suppression (lz_blank = 1): digit i > 0 shows 11111111 if it and every higher digit are 0. dp on a suppressed digit is still drawn. Digit 0 is never suppressed.
- blank[i] = 1 gives 11111111 and overrides everything else.
- A dark digit still has its enable bit asserted.

## Timing
- Reset values: segment = 8'hFF, enable = all ones, frame_tick = 0, prescaler = 0, ptr = NUM_DIGITS-1, snapshot = 0, blink phase = 0.
- For a tick at cycle T:
  - T+1: enable = all ones (dead cycle), segment = new pattern.
  - T+2: enable[ptr] = 0.
- Each digit is lit for TICK_DIV-1 of every TICK_DIV cycles. Frame period = NUM_DIGITS*TICK_DIV.
- First tick after reset release: cycle TICK_DIV-1, counted from the first non-reset edge. It wraps ptr to 0 and takes the first snapshot.
- rst asserted mid-frame returns every register to its reset value on the next edge. The partial frame is discarded.

## Configuration
- SEG_BLINK_EN defined:
  - A frame counter 0..BLINK_FRAMES-1 advances on each snapshot and toggles the blink phase when it wraps.
  - While phase = 1, a digit with snapshot blink[i] = 1 outputs 11111111.
- SEG_BLINK_EN undefined: no counter is built, the blink port is ignored, and outputs are unaffected.

## Test plan
All scenarios use NUM_DIGITS = 4, TICK_DIV = 4.
- Reset: hold rst 3 cycles → segment = FF, enable = 1111, frame_tick = 0. After release, first tick at cycle 3, enable = 1111 at cycle 4, enable = 1110 at cycle 5; frame_tick pulses at cycle 4, then every 16 cycles.
- Scan/decode: digits = 16'h1234, dp = 0010, hex_mode = 0 → slot0 10011001, slot1 00001100, slot2 00100101, slot3 10011111. enable rotates 1110 → 1101 → 1011 → 0111, with a 1111 dead cycle before each.
- Hex: digits = 16'hABCF → hex_mode = 1 gives slot0 01110001, slot3 00010001. hex_mode = 0 gives FF on all four slots.
- Leading zero + blank, lz_blank = 1:
  - 16'h0050 → slots 3 and 2 FF, slot1 01001001, slot0 00000011.
  - 16'h0000 → only slot0 lit.
  - blank = 0001 → slot0 FF.
- Snapshot coherence: change digits from 16'h1111 to 16'h2222 during slot 1 → remaining slots of that frame show "1". All slots show "2" after the next frame_tick.
- Blink with SEG_BLINK_EN, BLINK_FRAMES = 2, blink = 0001 → slot0 normal for 2 frames, FF for 2 frames, repeating. Without the macro, slot0 is always normal.

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A prescaler divides clk into digit slots; at each slot boundary the anodes
// go dark for one cycle (anti-ghosting) while the next segment pattern is
// registered, then the selected anode is driven. All decoding uses a snapshot
// of the inputs taken when the scan wraps to digit 0, so a frame never mixes
// old and new data.
//
// Optional feature: define SEG_BLINK_EN to build the blink frame counter.
// Without it the blink port is ignored.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   digits     4*NUM_DIGITS packed nibbles, digit 0 rightmost
//   dp         per-digit decimal point enable (active-high)
//   blank      per-digit force-dark (active-high)
//   blink      per-digit blink mask (SEG_BLINK_EN only)
//   hex_mode   1: values 10..15 show A b C d E F, 0: dark
//   lz_blank   leading-zero suppression enable
//   segment    {a,b,c,d,e,f,g,dp}, active-low, registered
//   enable     anode select, active-low, registered
//   frame_tick one-cycle pulse after each snapshot
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   enable,
    output logic                    frame_tick
);

    localparam int PTR_W = $clog2(NUM_DIGITS);
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0]         presc;
    logic [PTR_W-1:0]        ptr;
    logic                    dead;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_hex;
    logic                    snap_lz;

    logic                    tick;
    logic                    wrap;
    logic [PTR_W-1:0]        ptr_n;
    logic [4*NUM_DIGITS-1:0] n_digits;
    logic [NUM_DIGITS-1:0]   n_dp;
    logic [NUM_DIGITS-1:0]   n_blank;
    logic                    n_hex;
    logic                    n_lz;
    logic                    n_blink_dark;
    logic [3:0]              cur;
    logic                    lz_hit;
    logic [7:0]              pattern;

    // Segments a..g, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (!hex && v > 4'h9) s = 7'b1111111;
        return s;
    endfunction

    assign tick = (presc == LAST_PS);
    assign wrap = tick && (ptr == LAST_PTR);

`ifdef SEG_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] LAST_FC = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0]       frame_cnt;
    logic                  phase;
    logic                  snap_phase;
    logic [NUM_DIGITS-1:0] snap_blink;

    // The phase is captured with the snapshot so a whole frame uses one
    // phase value; the counter update at the same edge takes effect from
    // the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt  <= '0;
            phase      <= 1'b0;
            snap_phase <= 1'b0;
            snap_blink <= '0;
        end else if (wrap) begin
            snap_phase <= phase;
            snap_blink <= blink;
            if (frame_cnt == LAST_FC) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    always_comb begin
        n_blink_dark = 1'b0;
        if (wrap) n_blink_dark = phase && blink[ptr_n];
        else      n_blink_dark = snap_phase && snap_blink[ptr_n];
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink;
    assign n_blink_dark = 1'b0;
`endif

    // The pattern registered at a tick is for the next slot, and at a wrap
    // it must already see the snapshot being taken on that same edge.
    always_comb begin
        ptr_n    = (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
        n_digits = wrap ? digits   : snap_digits;
        n_dp     = wrap ? dp       : snap_dp;
        n_blank  = wrap ? blank    : snap_blank;
        n_hex    = wrap ? hex_mode : snap_hex;
        n_lz     = wrap ? lz_blank : snap_lz;
        cur      = n_digits[{ptr_n, 2'b00} +: 4];

        // Suppressed when this digit and every higher one are zero.
        lz_hit = n_lz && (ptr_n != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(ptr_n) && n_digits[4*j +: 4] != 4'h0) lz_hit = 1'b0;
        end

        pattern = {seg7(cur, n_hex), ~n_dp[ptr_n]};
        if (lz_hit)         pattern = {7'b1111111, ~n_dp[ptr_n]};
        if (n_blink_dark)   pattern = 8'hFF;
        if (n_blank[ptr_n]) pattern = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            ptr         <= LAST_PTR;
            dead        <= 1'b0;
            segment     <= 8'hFF;
            enable      <= '1;
            frame_tick  <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_hex    <= 1'b0;
            snap_lz     <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + PS_W'(1);
            dead       <= tick;
            frame_tick <= wrap;
            if (tick) begin
                ptr     <= ptr_n;
                segment <= pattern;
                enable  <= '1;
            end else if (dead) begin
                enable <= ~(NUM_DIGITS'(1) << ptr);
            end
            if (wrap) begin
                snap_digits <= digits;
                snap_dp     <= dp;
                snap_blank  <= blank;
                snap_hex    <= hex_mode;
                snap_lz     <= lz_blank;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        hex_mode;
    logic        lz_blank;
    logic [7:0]  segment;
    logic [3:0]  enable;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    seg_scan_mux #(.NUM_DIGITS(4), .TICK_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .dp        (dp),
        .blank     (blank),
        .blink     (blink),
        .hex_mode  (hex_mode),
        .lz_blank  (lz_blank),
        .segment   (segment),
        .enable    (enable),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            hex;
        logic            lz;
        logic [3:0][7:0] exp;   // exp[k] = expected segment for slot k
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Steps until frame_tick is seen (at most 40 cycles).
    task automatic wait_frame(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_tick not seen within 40 cycles", name);
        end
    endtask

    // Called on the frame_tick cycle F; checks dead and lit cycle of each
    // slot and returns at F+13 (slot 3 still lit).
    task automatic check_frame(input string name, input logic [3:0][7:0] exp);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s dead en s%0d", name, k), {4'h0, enable}, 8'h0F);
            check($sformatf("%s seg s%0d", name, k), segment, exp[k]);
            step();
            check($sformatf("%s en s%0d", name, k), {4'h0, enable}, {4'h0, ~(4'b0001 << k)});
            check($sformatf("%s lit seg s%0d", name, k), segment, exp[k]);
            if (k < 3) repeat (3) step();
        end
    endtask

    // Releases reset at a negedge (cycle 0) and checks the start-up
    // timeline; returns on the second frame_tick (cycle 20).
    task automatic release_and_check(input string name, input logic [7:0] first_seg);
        int n = 0;
        bit seen = 1'b0;
        rst = 1'b0;
        for (n = 1; n <= 5; n++) begin
            step();
            check($sformatf("%s frame_tick c%0d", name, n), {7'h0, frame_tick}, {7'h0, n == 4});
            check($sformatf("%s enable c%0d", name, n), {4'h0, enable}, (n == 5) ? 8'h0E : 8'h0F);
            if (n == 4) check($sformatf("%s seg c4", name), segment, first_seg);
        end
        for (n = 6; n <= 40 && !seen; n++) begin
            step();
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                check($sformatf("%s 2nd frame_tick cycle", name), 8'(n), 8'd20);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: second frame_tick missing", name);
        end
    endtask

    function automatic logic [7:0] blink_exp(input int f);
        return (BLINK_ON && (((f - 1) / 2) % 2 == 1)) ? 8'hFF : 8'b00000001;
    endfunction

    initial begin
        //                     digits    dp       blank    hex   lz    {slot3, slot2, slot1, slot0}
        vecs[0]  = '{16'h1234, 4'b0010, 4'b0000, 1'b0, 1'b0, {8'b10011111, 8'b00100101, 8'b00001100, 8'b10011001}};
        vecs[1]  = '{16'hABCF, 4'b0000, 4'b0000, 1'b1, 1'b0, {8'b00010001, 8'b11000001, 8'b01100011, 8'b01110001}};
        vecs[2]  = '{16'hABCF, 4'b0000, 4'b0000, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[3]  = '{16'h0050, 4'b0000, 4'b0000, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'b01001001, 8'b00000011}};
        vecs[4]  = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'b00000011}};
        vecs[5]  = '{16'h0050, 4'b0000, 4'b0001, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'b01001001, 8'hFF}};
        vecs[6]  = '{16'h0050, 4'b0100, 4'b0000, 1'b0, 1'b1, {8'hFF, 8'b11111110, 8'b01001001, 8'b00000011}};
        vecs[7]  = '{16'h0050, 4'b0000, 4'b0000, 1'b0, 1'b0, {8'b00000011, 8'b00000011, 8'b01001001, 8'b00000011}};
        vecs[8]  = '{16'h1234, 4'b1111, 4'b1000, 1'b0, 1'b0, {8'hFF, 8'b00100100, 8'b00001100, 8'b10011000}};
        vecs[9]  = '{16'h9E06, 4'b0000, 4'b0000, 1'b1, 1'b1, {8'b00001001, 8'b01100001, 8'b00000011, 8'b01000001}};
        vecs[10] = '{16'h7DB1, 4'b0000, 4'b0000, 1'b1, 1'b0, {8'b00011111, 8'b10000101, 8'b11000001, 8'b10011111}};

        // Reset held for 3 cycles.
        rst = 1'b1; digits = 16'h0000; dp = 4'b0000; blank = 4'b0000;
        blink = 4'b0000; hex_mode = 1'b0; lz_blank = 1'b0;
        repeat (3) begin
            step();
            check("reset segment", segment, 8'hFF);
            check("reset enable", {4'h0, enable}, 8'h0F);
            check("reset frame_tick", {7'h0, frame_tick}, 8'h00);
        end
        release_and_check("startup", 8'b00000011);

        // Decode vectors.
        for (int i = 0; i < 11; i++) begin
            digits = vecs[i].digits; dp = vecs[i].dp; blank = vecs[i].blank;
            hex_mode = vecs[i].hex; lz_blank = vecs[i].lz;
            wait_frame($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Snapshot coherence: change inputs during slot 1.
        digits = 16'h1111; dp = 4'b0000; blank = 4'b0000; hex_mode = 1'b0; lz_blank = 1'b0;
        wait_frame("coh a");
        check("coh s0", segment, 8'b10011111);
        repeat (5) step();
        digits = 16'h2222;
        check("coh s1", segment, 8'b10011111);
        repeat (3) step();
        check("coh s2", segment, 8'b10011111);
        repeat (4) step();
        check("coh s3", segment, 8'b10011111);
        wait_frame("coh b");
        check_frame("coh next", {8'b00100101, 8'b00100101, 8'b00100101, 8'b00100101});

        // Mid-frame reset while slot 3 is lit.
        check("pre-reset enable", {4'h0, enable}, 8'h07);
        rst = 1'b1;
        step();
        check("mid reset segment", segment, 8'hFF);
        check("mid reset enable", {4'h0, enable}, 8'h0F);
        check("mid reset frame_tick", {7'h0, frame_tick}, 8'h00);
        step();
        digits = 16'h0008; blink = 4'b0001;
        release_and_check("restart", blink_exp(1));

        // Blink on slot 0, frames 2..6 after reset.
        check("blink f2", segment, blink_exp(2));
        for (int f = 3; f <= 6; f++) begin
            wait_frame($sformatf("blink f%0d", f));
            check($sformatf("blink f%0d", f), segment, blink_exp(f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
